alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 WIDTH  parameter, default 16  datapath width; shift amount uses low log2(WIDTH) bits of cmd_b.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  3  opcode: 000 ADD, 001 SUB, 010 SRA, 011 SRL, 100 SLL, 101 AND, 110 OR, 111 illegal.
REQ-007 cmd_a, cmd_b  input  WIDTH each  operands; for shifts cmd_b[log2(WIDTH)-1:0] is the shift amount n.
REQ-008 alu_op  output  3  opcode driven to the ALU datapath.
REQ-009 alu_a, alu_b  output  WIDTH each  operands driven to the ALU datapath.
REQ-010 alu_result  input  WIDTH  combinational ALU result for current alu_op/alu_a/alu_b.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  consumer accepts result.
REQ-013 rsp_data  output  WIDTH  result.
REQ-014 rsp_err  output  1  command was illegal (op 111).

Function
REQ-015 The block SHALL implement FSM states IDLE, EXEC, SHIFT, DONE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; accept = cmd_valid & cmd_ready; op, operands and n are registered on accept.
REQ-017 On accept: ADD/SUB/AND/OR, or shift with n=0, or op 111 -> EXEC; shift with n>=1 -> SHIFT with count=n, acc=cmd_a.
REQ-018 EXEC (one cycle): drives alu_op=op, alu_a=A, alu_b=B; captures alu_result into rsp_data; -> DONE. For shift n=0, rsp_data=A. For op 111, rsp_data=0, rsp_err=1, ALU outputs held idle.
REQ-019 SHIFT: each cycle drives alu_op=op, alu_a=acc, alu_b=1; acc<=alu_result; count decrements; on count==1 edge, -> DONE with rsp_data=final acc.
REQ-020 Latency: rsp_valid rises 1 cycle after accept for non-shift, shift n=0 and illegal; n cycles after accept for shift n>=1.
REQ-021 DONE: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid & rsp_ready; then -> IDLE (next accept no earlier than following cycle).
REQ-022 Outside EXEC/SHIFT, alu_op SHALL be 000 and alu_a=alu_b=0.
REQ-023 Shift amounts wrap modulo WIDTH (only low log2(WIDTH) bits used); no cycle exceeds WIDTH-1 shift steps.
REQ-024 cmd_valid while not in IDLE SHALL be ignored (not lost: cmd_ready=0 backpressures).

Reset
REQ-025 rst asserted (any time, including mid-SHIFT or DONE) SHALL force IDLE immediately; in-flight command discarded.
REQ-026 Reset values: cmd_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_data=0, alu_op=000, alu_a=alu_b=0, count=0.

Configuration
REQ-027 Macro ALU_SEQ_PERF_EN defined: adds output perf_ops [15:0], count of completed responses (rsp_valid & rsp_ready), saturating at 16'hFFFF, cleared by rst.
REQ-028 Macro ALU_SEQ_PERF_EN undefined: perf_ops port and counter logic absent; all other behaviour identical.

Structure
REQ-029 Package alu_seq_pkg SHALL hold opcode constants (ADD..OR, ILLEGAL=111), FSM state typedef, default WIDTH.
REQ-030 Perf counter SHALL be sub-module alu_seq_perf, instantiated only under ALU_SEQ_PERF_EN; FSM and datapath regs stay in alu_seq.

Verification
REQ-031 ADD a=0x0005 b=0x0003, rsp_ready=1 -> alu_op=000 in EXEC, rsp_valid 1 cycle after accept, rsp_data=0x0008, rsp_err=0.
REQ-032 SLL a=0x0001 b=0x0004 (ALU model 1-bit shift) -> 4 SHIFT cycles with alu_b=1, rsp_data=0x0010 at cycle 4; SRA a=0x8000 n=3 -> 0xF000.
REQ-033 SRL a=0x1234 b=0x0000 -> EXEC only, rsp_data=0x1234 after 1 cycle; b=0x0010 (WIDTH=16) treated as n=0 likewise.
REQ-034 op=111 -> rsp_err=1, rsp_data=0 after 1 cycle; alu_op stays 000 throughout.
REQ-035 rsp_ready held 0 for 5 cycles in DONE -> rsp_valid/rsp_data stable, cmd_ready=0, second cmd_valid not accepted until handshake.
REQ-036 rst pulsed during SHIFT (n=10, after 3 steps) -> immediate IDLE, rsp_valid=0, no response issued; with ALU_SEQ_PERF_EN, perf_ops=0 and increments once per completed response thereafter.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq command sequencer: opcodes, FSM states
// and the default datapath width.
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_SRA     = 3'b010;
  localparam logic [2:0] OP_SRL     = 3'b011;
  localparam logic [2:0] OP_SLL     = 3'b100;
  localparam logic [2:0] OP_AND     = 3'b101;
  localparam logic [2:0] OP_OR      = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Shifts are sequenced one bit per cycle through the external ALU
  function automatic logic is_shift(input logic [2:0] op);
    logic res;
    case (op)
      OP_SRA, OP_SRL, OP_SLL: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_seq_perf.sv
// Saturating count of completed responses for alu_seq (built only when
// ALU_SEQ_PERF_EN is defined).
module alu_seq_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] perf_ops
);

  // Response counter, sticks at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops <= 16'h0000;
    end else if (inc && (perf_ops != 16'hFFFF)) begin
      perf_ops <= perf_ops + 16'h0001;
    end else begin
      perf_ops <= perf_ops;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Command sequencer driving an external combinational ALU; shifts run one bit
// per cycle. Optional perf counter output under macro ALU_SEQ_PERF_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]      perf_ops
`endif
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           state_r, next_state_s;
  logic [2:0]       op_r, op_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [SH_W-1:0]  count_r, count_s;
  logic [SH_W-1:0]  shamt_s;
  logic             cmd_ready_r, cmd_ready_s;
  logic             rsp_valid_r, rsp_valid_s;
  logic [WIDTH-1:0] rsp_data_r, rsp_data_s;
  logic             rsp_err_r, rsp_err_s;
  logic [2:0]       alu_op_r, alu_op_s;
  logic [WIDTH-1:0] alu_a_r, alu_a_s;
  logic [WIDTH-1:0] alu_b_r, alu_b_s;

  assign shamt_s = cmd_b[SH_W-1:0];

  // Next-state and datapath register updates
  always_comb begin
    next_state_s = state_r;
    op_s         = op_r;
    a_s          = a_r;
    b_s          = b_r;
    acc_s        = acc_r;
    count_s      = count_r;
    rsp_data_s   = rsp_data_r;
    rsp_err_s    = rsp_err_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_s      = cmd_op;
          a_s       = cmd_a;
          b_s       = cmd_b;
          acc_s     = cmd_a;
          count_s   = shamt_s;
          rsp_err_s = 1'b0;
          if (is_shift(cmd_op) && (shamt_s != {SH_W{1'b0}})) begin
            next_state_s = ST_SHIFT;
          end else begin
            next_state_s = ST_EXEC;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        next_state_s = ST_DONE;
        case (op_r)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            rsp_data_s = alu_result;
            rsp_err_s  = 1'b0;
          end
          OP_SRA, OP_SRL, OP_SLL: begin
            rsp_data_s = a_r;
            rsp_err_s  = 1'b0;
          end
          OP_ILLEGAL: begin
            rsp_data_s = {WIDTH{1'b0}};
            rsp_err_s  = 1'b1;
          end
          default: begin
            rsp_data_s = {WIDTH{1'b0}};
            rsp_err_s  = 1'b1;
          end
        endcase
      end
      ST_SHIFT: begin
        acc_s   = alu_result;
        count_s = count_r - SH_W'(1);
        // a zero count here can only come from corruption; finish rather than spin
        if (count_r <= SH_W'(1)) begin
          next_state_s = ST_DONE;
          rsp_data_s   = alu_result;
          count_s      = {SH_W{1'b0}};
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the state being entered, so every output is a flop
  always_comb begin
    cmd_ready_s = (next_state_s == ST_IDLE);
    rsp_valid_s = (next_state_s == ST_DONE);
    alu_op_s    = OP_ADD;
    alu_a_s     = {WIDTH{1'b0}};
    alu_b_s     = {WIDTH{1'b0}};
    case (next_state_s)
      ST_EXEC: begin
        if (op_s != OP_ILLEGAL) begin
          alu_op_s = op_s;
          alu_a_s  = a_s;
          alu_b_s  = b_s;
        end else begin
          alu_op_s = OP_ADD;
          alu_a_s  = {WIDTH{1'b0}};
          alu_b_s  = {WIDTH{1'b0}};
        end
      end
      ST_SHIFT: begin
        alu_op_s = op_s;
        alu_a_s  = acc_s;
        alu_b_s  = WIDTH'(1);
      end
      default: begin
        alu_op_s = OP_ADD;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_ADD;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      count_r     <= {SH_W{1'b0}};
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
      alu_op_r    <= OP_ADD;
      alu_a_r     <= {WIDTH{1'b0}};
      alu_b_r     <= {WIDTH{1'b0}};
    end else begin
      state_r     <= next_state_s;
      op_r        <= op_s;
      a_r         <= a_s;
      b_r         <= b_s;
      acc_r       <= acc_s;
      count_r     <= count_s;
      cmd_ready_r <= cmd_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      rsp_err_r   <= rsp_err_s;
      alu_op_r    <= alu_op_s;
      alu_a_r     <= alu_a_s;
      alu_b_r     <= alu_b_s;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign alu_op    = alu_op_r;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;

`ifdef ALU_SEQ_PERF_EN
  alu_seq_perf u_perf (
    .clk      (clk),
    .rst      (rst),
    .inc      (rsp_valid_r & rsp_ready),
    .perf_ops (perf_ops)
  );
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random commands checked
// against a whole-operation reference model; perf counter checked when enabled.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_a = 16'd0;
  logic [15:0] cmd_b = 16'd0;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_ops;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_perf = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_ops   (perf_ops)
`endif
  );

  // External combinational ALU
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = $unsigned($signed(alu_a) >>> alu_b[3:0]);
      3'd3:    alu_result = alu_a >> alu_b[3:0];
      3'd4:    alu_result = alu_a << alu_b[3:0];
      3'd5:    alu_result = alu_a & alu_b;
      3'd6:    alu_result = alu_a | alu_b;
      default: alu_result = 16'd0;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_perf(input string name);
`ifdef ALU_SEQ_PERF_EN
    n_cmp++;
    if (perf_ops !== 16'(exp_perf)) begin
      n_bad++;
      $display("FAIL %s perf_ops got %0d exp %0d", name, perf_ops, exp_perf);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_data, alu_op, alu_a, alu_b} !== {1'b1, 1'b0, 1'b0, 16'd0, 3'd0, 16'd0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_state got rdy=%b v=%b e=%b d=%h op=%h a=%h b=%h exp rdy=1 v=0 e=0 d=0 op=0 a=0 b=0",
               cmd_ready, rsp_valid, rsp_err, rsp_data, alu_op, alu_a, alu_b);
    end
    exp_perf = 0;
    check_perf("reset");
  endtask

  // Issue one command, follow it to its response and check everything on the way
  task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int stall);
    logic [15:0] exp_data;
    logic signed [15:0] sa;
    logic exp_err;
    int n, exp_lat, lat, shift_cyc, w;
    bit alu_bad, is_sh;
    n = int'(b[3:0]);
    sa = a;
    exp_err = 1'b0;
    is_sh = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
    case (op)
      3'd0:    exp_data = a + b;
      3'd1:    exp_data = a - b;
      3'd2:    exp_data = $unsigned(sa >>> n);
      3'd3:    exp_data = a >> n;
      3'd4:    exp_data = a << n;
      3'd5:    exp_data = a & b;
      3'd6:    exp_data = a | b;
      default: begin exp_data = 16'd0; exp_err = 1'b1; end
    endcase
    exp_lat = (is_sh && n != 0) ? n : 1;

    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (!cmd_ready) begin
      n_bad++;
      $display("FAIL wait_ready got cmd_ready=0 exp 1 within 50 cycles");
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; shift_cyc = 0; alu_bad = 1'b0;
    while (!rsp_valid && lat < 40) begin
      if (op == 3'd7) begin
        if (alu_op !== 3'd0 || alu_a !== 16'd0 || alu_b !== 16'd0) alu_bad = 1'b1;
      end else if (is_sh && n != 0) begin
        if (alu_op === op && alu_b === 16'd1) shift_cyc++;
        else alu_bad = 1'b1;
      end else if (!is_sh) begin
        if (alu_op !== op || alu_a !== a || alu_b !== b) alu_bad = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_bad++;
      $display("FAIL latency op=%0d a=%h b=%h got %0d exp %0d", op, a, b, lat, exp_lat);
    end
    n_cmp++;
    if (rsp_data !== exp_data || rsp_err !== exp_err) begin
      n_bad++;
      $display("FAIL result op=%0d a=%h b=%h got %h/err%b exp %h/err%b", op, a, b, rsp_data, rsp_err, exp_data, exp_err);
    end
    n_cmp++;
    if (alu_bad) begin
      n_bad++;
      $display("FAIL alu_drive op=%0d a=%h b=%h got bad ALU drive exp op/operands per phase", op, a, b);
    end
    if (is_sh && n != 0) begin
      n_cmp++;
      if (shift_cyc != n) begin
        n_bad++;
        $display("FAIL shift_steps op=%0d got %0d exp %0d", op, shift_cyc, n);
      end
    end
    n_cmp++;
    if (cmd_ready !== 1'b0 || alu_op !== 3'd0 || alu_a !== 16'd0 || alu_b !== 16'd0) begin
      n_bad++;
      $display("FAIL done_idle_outputs got rdy=%b op=%h a=%h b=%h exp 0 0 0 0", cmd_ready, alu_op, alu_a, alu_b);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_data || cmd_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold cyc=%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=0", i, rsp_valid, rsp_data, cmd_ready, exp_data);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    if (exp_perf < 65535) exp_perf++;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL handshake got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, cmd_ready);
    end
    check_perf("after_rsp");
  endtask

  task automatic test_directed();
    run_cmd(3'd0, 16'h0005, 16'h0003, 0);
    run_cmd(3'd4, 16'h0001, 16'h0004, 0);
    run_cmd(3'd2, 16'h8000, 16'h0003, 0);
    run_cmd(3'd3, 16'h1234, 16'h0000, 0);
    run_cmd(3'd3, 16'h1234, 16'h0010, 0);
    run_cmd(3'd7, 16'hABCD, 16'h1234, 0);
    run_cmd(3'd4, 16'h0001, 16'h000F, 1);
    run_cmd(3'd1, 16'h0000, 16'h0001, 5);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 16'd1; cmd_b = 16'd2;
    @(negedge clk);
    cmd_op = 3'd1; cmd_a = 16'd9; cmd_b = 16'd4;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'd3 || cmd_ready !== 1'b0 || alu_op !== 3'd0) begin
        n_bad++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h rdy=%b op=%h exp v=1 d=0003 rdy=0 op=0", i, rsp_valid, rsp_data, cmd_ready, alu_op);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    if (exp_perf < 65535) exp_perf++;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release got rdy=%b v=%b exp rdy=1 v=0", cmd_ready, rsp_valid);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if (alu_op !== 3'd1 || alu_a !== 16'd9 || alu_b !== 16'd4) begin
      n_bad++;
      $display("FAIL bp_second_exec got op=%h a=%h b=%h exp 1 0009 0004", alu_op, alu_a, alu_b);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'd5) begin
      n_bad++;
      $display("FAIL bp_second_rsp got v=%b d=%h exp v=1 d=0005", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    if (exp_perf < 65535) exp_perf++;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_perf("bp");
  endtask

  task automatic test_reset_mid_shift();
    bit seen;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 16'h0001; cmd_b = 16'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_op !== 3'd0 || alu_a !== 16'd0 || alu_b !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_mid_shift got rdy=%b v=%b op=%h a=%h b=%h exp 1 0 0 0 0", cmd_ready, rsp_valid, alu_op, alu_a, alu_b);
    end
    exp_perf = 0;
    #1 rst = 1'b0;
    seen = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL rst_no_response got rsp_valid=1 exp no response after reset");
    end
    check_perf("after_rst");
    run_cmd(3'd5, 16'hF0F0, 16'h3C3C, 0);
  endtask

  task automatic test_random();
    logic [15:0] b;
    for (int i = 0; i < 40; i++) begin
      b = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      run_cmd(3'($urandom_range(0, 7)), 16'($urandom), b, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
